// File: rtl/shape_sender.sv
// Replays a captured 12-bit master pattern as LoadShape/ShapeLocation/LoadShapeNow
// transfers in a programmable location order, with optional idle gaps between offers.
module shape_sender #(
  parameter int GAP       = 0,
  parameter int NUM_SLOTS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [3*NUM_SLOTS-1:0]   Pattern,
  input  logic [2*NUM_SLOTS-1:0]   Order,
  input  logic                     LoadReady,
  output logic [2:0]               LoadShape,
  output logic [1:0]               ShapeLocation,
  output logic                     LoadShapeNow,
  output logic                     Busy,
  output logic                     SendDone
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] K_LAST = 2'(NUM_SLOTS - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP);

  logic [1:0]             state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [3:0]             gap_q, gap_d;
  logic [3*NUM_SLOTS-1:0] pat_q, pat_d;
  logic [2*NUM_SLOTS-1:0] ord_q, ord_d;

  logic [1:0] cur_loc;
  logic [3:0] shape_idx;
  logic [2:0] cur_shape;
  logic       in_send;

  // Location comes from the order entry k; the shape is looked up by that location.
  assign cur_loc   = ord_q[{k_q, 1'b0} +: 2];
  assign shape_idx = {1'b0, cur_loc, 1'b0} + {2'b00, cur_loc};
  assign cur_shape = pat_q[shape_idx +: 3];
  assign in_send   = (state_q == S_SEND);

  assign LoadShapeNow  = in_send;
  assign ShapeLocation = in_send ? cur_loc   : 2'b00;
  assign LoadShape     = in_send ? cur_shape : 3'b000;
  assign Busy          = in_send || (state_q == S_GAP);
  assign SendDone      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    ord_d   = ord_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pat_d   = Pattern;
          ord_d   = Order;
          k_d     = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (LoadReady) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 2'd1;
            if (GAP > 0) begin
              gap_d   = GAP_LD;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        // Leaving when the counter reads 1 gives exactly GAP idle cycles.
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      gap_q   <= 4'd0;
      pat_q   <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      ord_q   <= ord_d;
    end
  end

endmodule

// File: tb/tb_shape_sender.sv
// Scoreboard bench for shape_sender: a GAP=0 instance and a GAP=2 instance share clock/reset.
module tb_shape_sender;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        st0, rdy0, now0, busy0, done0;
  logic [11:0] pat0;
  logic [7:0]  ord0;
  logic [2:0]  shp0;
  logic [1:0]  loc0;

  logic        st2, rdy2, now2, busy2, done2;
  logic [11:0] pat2;
  logic [7:0]  ord2;
  logic [2:0]  shp2;
  logic [1:0]  loc2;

  shape_sender #(.GAP(0), .NUM_SLOTS(4)) u0 (
    .clock(clock), .reset(reset), .Start(st0), .Pattern(pat0), .Order(ord0),
    .LoadReady(rdy0), .LoadShape(shp0), .ShapeLocation(loc0),
    .LoadShapeNow(now0), .Busy(busy0), .SendDone(done0)
  );

  shape_sender #(.GAP(2), .NUM_SLOTS(4)) u2 (
    .clock(clock), .reset(reset), .Start(st2), .Pattern(pat2), .Order(ord2),
    .LoadReady(rdy2), .LoadShape(shp2), .ShapeLocation(loc2),
    .LoadShapeNow(now2), .Busy(busy2), .SendDone(done2)
  );

  localparam logic [11:0] PAT = 12'b001_010_101_110;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboards: expected {loc,shape} offers and expected SendDone cycle per instance.
  logic [4:0] exp0_q[$];
  logic [4:0] exp2_q[$];
  int         done0_q[$];
  int         done2_q[$];

  // Loopback receiver model on u0: first write to a location wins.
  logic [11:0] master;
  logic [3:0]  fill;
  int          low2 = 0;

  always @(negedge clock) begin
    if (reset) begin
      if (now0 && rdy0) begin
        if (exp0_q.size() == 0) flag("u0 unexpected offer");
        else chk("u0 offer", {loc0, shp0}, exp0_q.pop_front());
        if (!fill[loc0]) begin
          fill[loc0] = 1'b1;
          master[3*loc0 +: 3] = shp0;
        end
      end
      if (done0) begin
        if (done0_q.size() == 0) flag("u0 unexpected SendDone");
        else chk("u0 SendDone cycle", cyc, done0_q.pop_front());
        chk("u0 Busy at SendDone", busy0, 0);
        chk("u0 offers pending at SendDone", exp0_q.size(), 0);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      low2 = 0;
    end else begin
      if (now2 && rdy2) begin
        if (exp2_q.size() == 0) flag("u2 unexpected offer");
        else chk("u2 offer", {loc2, shp2}, exp2_q.pop_front());
      end
      if (busy2 && !now2) begin
        low2++;
      end else if (now2) begin
        if (low2 != 0) chk("u2 gap length", low2, 2);
        low2 = 0;
      end
      if (done2) begin
        if (done2_q.size() == 0) flag("u2 unexpected SendDone");
        else chk("u2 SendDone cycle", cyc, done2_q.pop_front());
        chk("u2 Busy at SendDone", busy2, 0);
        chk("u2 offers pending at SendDone", exp2_q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push0(input logic [1:0] l, input logic [2:0] s);
    exp0_q.push_back({l, s});
  endtask

  task automatic push2(input logic [1:0] l, input logic [2:0] s);
    exp2_q.push_back({l, s});
  endtask

  task automatic push_fwd0();
    push0(2'd0, 3'b110); push0(2'd1, 3'b101); push0(2'd2, 3'b010); push0(2'd3, 3'b001);
  endtask

  task automatic push_fwd2();
    push2(2'd0, 3'b110); push2(2'd1, 3'b101); push2(2'd2, 3'b010); push2(2'd3, 3'b001);
  endtask

  task automatic clr_model();
    master = 12'd0;
    fill   = 4'd0;
  endtask

  // Pulse Start for one cycle; returns in cycle 1 (first offer visible).
  task automatic send0(input logic [11:0] p, input logic [7:0] o, input int extra);
    pat0 = p; ord0 = o; st0 = 1'b1;
    tick();
    st0 = 1'b0;
    done0_q.push_back(cyc + 4 + extra);
    chk("u0 Busy in cycle 1", busy0, 1);
    chk("u0 LoadShapeNow in cycle 1", now0, 1);
  endtask

  task automatic send2(input logic [11:0] p, input logic [7:0] o);
    pat2 = p; ord2 = o; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    done2_q.push_back(cyc + 4 + 6);
    chk("u2 Busy in cycle 1", busy2, 1);
  endtask

  task automatic wait0(input string name);
    int n = 0;
    while ((exp0_q.size() != 0 || done0_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) flag({name, " timeout"});
    tick();
  endtask

  task automatic wait2(input string name);
    int n = 0;
    while ((exp2_q.size() != 0 || done2_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) flag({name, " timeout"});
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    st0 = 1'b0; pat0 = '0; ord0 = '0; rdy0 = 1'b0;
    st2 = 1'b0; pat2 = '0; ord2 = '0; rdy2 = 1'b0;
    clr_model();
    #1;
    chk("u0 reset outputs", {shp0, loc0, now0, busy0, done0}, 0);
    chk("u2 reset outputs", {shp2, loc2, now2, busy2, done2}, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: forward order, no backpressure
    rdy0 = 1'b1;
    clr_model(); push_fwd0();
    send0(PAT, 8'b11_10_01_00, 0);
    wait0("scn1");

    // 2: reverse order, loopback builds the full master
    clr_model();
    push0(2'd3, 3'b001); push0(2'd2, 3'b010); push0(2'd1, 3'b101); push0(2'd0, 3'b110);
    send0(PAT, 8'b00_01_10_11, 0);
    wait0("scn2");
    chk("scn2 master", master, 12'b001_010_101_110);
    chk("scn2 LoadDone", &fill, 1);

    // 3: three stall cycles on entry 1
    clr_model(); push_fwd0();
    send0(PAT, 8'b11_10_01_00, 3);
    tick();
    rdy0 = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("scn3 hold LoadShapeNow", now0, 1);
      chk("scn3 hold offer", {loc0, shp0}, {2'd1, 3'b101});
      tick();
    end
    rdy0 = 1'b1;
    wait0("scn3");

    // 4: duplicate locations are all sent
    clr_model();
    push0(2'd0, 3'b110); push0(2'd0, 3'b110); push0(2'd1, 3'b101); push0(2'd1, 3'b101);
    send0(PAT, 8'b01_01_00_00, 0);
    wait0("scn4");
    chk("scn4 master", master, 12'b000_000_101_110);
    chk("scn4 LoadDone", &fill, 0);

    // 5: GAP=2 instance
    rdy2 = 1'b1;
    push_fwd2();
    send2(PAT, 8'b11_10_01_00);
    wait2("scn5");

    // 6a: reset during the gap after entry 2
    push_fwd2();
    send2(PAT, 8'b11_10_01_00);
    repeat (7) tick();
    chk("scn6 in gap", {busy2, now2}, 2'b10);
    reset = 1'b0;
    #1;
    chk("scn6 async reset outputs", {shp2, loc2, now2, busy2, done2}, 0);
    exp2_q.delete();
    done2_q.delete();
    tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("scn6 idle after reset", busy2, 0);

    // 6b: fresh Start restarts at entry 0
    push_fwd2();
    send2(PAT, 8'b11_10_01_00);
    wait2("scn6b");

    // 6c: Start mid-send is ignored, inputs may change after capture
    clr_model(); push_fwd0();
    send0(PAT, 8'b11_10_01_00, 0);
    st0 = 1'b1; pat0 = 12'hFFF; ord0 = 8'h00;
    tick();
    st0 = 1'b0;
    wait0("scn6c");
    repeat (10) tick();
    chk("scn6c master", master, 12'b001_010_101_110);

    chk("u0 scoreboard drained", exp0_q.size() + done0_q.size(), 0);
    chk("u2 scoreboard drained", exp2_q.size() + done2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
